jts16_gfx_rom: RTL
==================

# jts16_gfx_rom

Graphics ROM responder for the System 16 video subsystem. It serves the tile, scroll and sprite read requests that the video layers issue (`char_addr`/`char_ok`, `scr1_addr`/`scr1_ok`, `scr2_addr`/`scr2_ok`, `obj_cs`/`obj_addr`/`obj_ok`) from a single SDRAM read port. It sits between the video top and the SDRAM controller. Each slot keeps its last fetched word and raises `ok` only while the requested address matches it.

## Interface
Parameters:
- `CHAR_OFFSET`, 22'h00_0000, SDRAM 16-bit word base of the char ROM.
- `SCR_OFFSET`, 22'h01_0000, SDRAM word base of the scroll ROM, shared by scr1 and scr2.
- `OBJ_OFFSET`, 22'h10_0000, SDRAM word base of the sprite ROM.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `char_addr` in 13: char slot 32-bit word address; slot always enabled.
- `char_ok` out 1 / `char_data` out 32: char slot result.
- `scr1_addr`, `scr2_addr` in 17: scroll slot 32-bit word addresses; always enabled.
- `scr1_ok`, `scr2_ok` out 1 / `scr1_data`, `scr2_data` out 32: scroll slot results.
- `obj_cs` in 1 / `obj_addr` in 20: sprite slot enable and 16-bit word address.
- `obj_ok` out 1 / `obj_data` out 16: sprite slot result.
- `sdram_req` out 1 / `sdram_addr` out 22: SDRAM read request and 16-bit word address.
- `sdram_ack` in 1: request accepted (one-cycle pulse).
- `sdram_rdy` in 1 / `sdram_din` in 32: read data valid (2-word burst, low word in [15:0]).
- `st_addr` in 8 / `st_dout` out 8: status dump.

## Operation
- Per slot: `last_addr`, `valid`, data register.
- Slot pending = enabled & (!valid | addr != last_addr).
- `ok` = enabled & valid & (addr == last_addr). This is combinational from registers, so `ok` drops in the same cycle the address changes.
- Address mapping:
  - char: `CHAR_OFFSET + {char_addr,1'b0}`
  - scr1/scr2: `SCR_OFFSET + {scrN_addr,1'b0}`
  - obj: `OBJ_OFFSET + obj_addr`
  - All sums are 22-bit and wrap modulo 2^22.
- FSM:
  - IDLE: if any slot is pending, select one by round-robin in the order char, scr1, scr2, obj, starting after the last served slot. Latch the slot id and its current address. Register `sdram_req`=1 and the mapped `sdram_addr`. Go to REQ.
  - REQ: hold `sdram_req` and `sdram_addr`. On `sdram_ack`, clear `sdram_req` and go to WAIT. `sdram_rdy` is ignored in REQ.
  - WAIT: on `sdram_rdy`, write `sdram_din` to the selected slot (obj takes [15:0]). Set `last_addr` to the latched address and `valid`=1. Go to IDLE.
- If the slot address changes, or `obj_cs` drops, during REQ/WAIT, the fetch still completes and is stored under the latched address. `ok` stays low until the address matches. The slot becomes pending again if still enabled.
- Changing `obj_cs` does not clear `valid`.

## Timing
- Reset values:
  - state IDLE, round-robin pointer at obj (so char is served first)
  - all `valid`=0 and all `ok`=0
  - all data registers 0, `last_addr` 0
  - `sdram_req`=0, `sdram_addr`=0, `st_dout`=0
- Minimum latency, with the address changing at cycle N and the FSM idle:
  - `sdram_req` high at N+1
  - `sdram_ack` at N+1, giving WAIT at N+2
  - `sdram_rdy` at N+2, giving `ok` and data valid at N+3
- Latency otherwise grows by one cycle per cycle of ack/rdy wait, plus any fetches queued ahead.
- Worst-case wait is three other fetches.
- `sdram_addr` is stable whenever `sdram_req`=1.
- Reset asserted mid-fetch returns to the reset state on the next edge; a late `sdram_rdy` is then ignored.

## Configuration
- `JTS16_ROMSTAT_EN` defined:
  - One 8-bit wrapping counter per slot counts completed fetches; all counters clear on reset.
  - `st_dout` = counter selected by `st_addr[1:0]` (0 char, 1 scr1, 2 scr2, 3 obj), registered.
- Undefined: no counters are built and `st_dout` is tied to 0.

## Test plan
- Reset, then `char_addr`=13'h0005 with immediate ack/rdy, `sdram_din`=32'hCAFE1234 → `sdram_addr`=CHAR_OFFSET+22'h0A; `char_ok`=1 with `char_data`=32'hCAFE1234 three cycles after the request starts.
- `obj_cs`=0 with every other slot valid → `sdram_req` never asserts; `obj_ok`=0. Then `obj_cs`=1, `obj_addr`=20'h00010, `sdram_din`=32'hXXXX_BEEF → `sdram_addr`=OBJ_OFFSET+22'h10; `obj_data`=16'hBEEF.
- All four slots pending at once with ack/rdy delayed 5 cycles each → service order char, scr1, scr2, obj; no slot is served twice before all four are done.
- Change `scr1_addr` from 17'h100 to 17'h101 while in WAIT → the first fetch is stored and `scr1_ok` stays 0; a second request follows for `SCR_OFFSET`+22'h202, then `scr1_ok`=1.
- Assert `rst` for one cycle during WAIT, followed by a `sdram_rdy` pulse → all `ok`=0 and `sdram_req`=0; the pulse leaves no slot valid.
- With `JTS16_ROMSTAT_EN`: three char fetches and one obj fetch → `st_addr`=0 reads 3 and `st_addr`=3 reads 1. Without the macro, `st_dout` reads 0.

Source files
------------

// File: rtl/jts16_gfx_rom_if.sv
// Bus bundle for jts16_gfx_rom: video-layer read slots, SDRAM read port and status dump.
// The master side is the environment (video layers + SDRAM controller); the slave side is the ROM responder.
interface jts16_gfx_rom_if;
  logic [12:0] char_addr;
  logic        char_ok;
  logic [31:0] char_data;

  logic [16:0] scr1_addr;
  logic        scr1_ok;
  logic [31:0] scr1_data;
  logic [16:0] scr2_addr;
  logic        scr2_ok;
  logic [31:0] scr2_data;

  logic        obj_cs;
  logic [19:0] obj_addr;
  logic        obj_ok;
  logic [15:0] obj_data;

  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [31:0] sdram_din;

  logic [7:0]  st_addr;
  logic [7:0]  st_dout;

  modport master (
    output char_addr, scr1_addr, scr2_addr, obj_cs, obj_addr,
    output sdram_ack, sdram_rdy, sdram_din, st_addr,
    input  char_ok, char_data, scr1_ok, scr1_data, scr2_ok, scr2_data,
    input  obj_ok, obj_data, sdram_req, sdram_addr, st_dout
  );

  modport slave (
    input  char_addr, scr1_addr, scr2_addr, obj_cs, obj_addr,
    input  sdram_ack, sdram_rdy, sdram_din, st_addr,
    output char_ok, char_data, scr1_ok, scr1_data, scr2_ok, scr2_data,
    output obj_ok, obj_data, sdram_req, sdram_addr, st_dout
  );
endinterface

// File: rtl/jts16_gfx_rom.sv
// System 16 graphics ROM responder: four cached read slots served round-robin from one SDRAM port.
// Optional per-slot fetch counters on st_dout when JTS16_ROMSTAT_EN is defined.
module jts16_gfx_rom #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00_0000,
  parameter logic [21:0] SCR_OFFSET  = 22'h01_0000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h10_0000
) (
  input logic              clk,
  input logic              rst,
  jts16_gfx_rom_if.slave   bus
);
  localparam int NSLOT = 4;  // 0 char, 1 scr1, 2 scr2, 3 obj

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [19:0] cur_addr  [NSLOT];
  logic [21:0] map_addr  [NSLOT];
  logic [19:0] last_addr [NSLOT];
  logic [31:0] data      [NSLOT];
  logic [NSLOT-1:0] en, match, pending, valid;
  logic [1:0]  last_slot, sel, pick, idx;
  logic        pick_ok;
  logic [19:0] sel_addr;
  logic        req_q;
  logic [21:0] addr_q;

  // Slot addresses zero-extended to a common width so one comparator shape fits all slots.
  always_comb begin
    cur_addr[0] = {7'd0, bus.char_addr};
    cur_addr[1] = {3'd0, bus.scr1_addr};
    cur_addr[2] = {3'd0, bus.scr2_addr};
    cur_addr[3] = bus.obj_addr;
    map_addr[0] = CHAR_OFFSET + {8'd0, bus.char_addr, 1'b0};
    map_addr[1] = SCR_OFFSET  + {4'd0, bus.scr1_addr, 1'b0};
    map_addr[2] = SCR_OFFSET  + {4'd0, bus.scr2_addr, 1'b0};
    map_addr[3] = OBJ_OFFSET  + {2'd0, bus.obj_addr};
    en          = {bus.obj_cs, 3'b111};
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      match[i]   = valid[i] && (cur_addr[i] == last_addr[i]);
      pending[i] = en[i] && !match[i];
    end
  end

  // Scan downward so the slot nearest after last_slot wins; k=NSLOT wraps back to last_slot itself.
  // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
  always_comb begin
    pick    = last_slot;
    pick_ok = 1'b0;
    idx     = last_slot;
    for (int k = NSLOT; k >= 1; k--) begin
      idx = last_slot + 2'(k);
      if (pending[idx]) begin
        pick    = idx;
        pick_ok = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_slot <= 2'd3;
      sel       <= 2'd0;
      sel_addr  <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid     <= '0;
      // NOTE: the slot store is only four entries and must read back 0 after reset, so it is reset like flops.
      for (int i = 0; i < NSLOT; i++) begin
        last_addr[i] <= '0;
        data[i]      <= '0;
      end
    end else begin
      case (state)
        IDLE: if (pick_ok) begin
          sel       <= pick;
          last_slot <= pick;
          sel_addr  <= cur_addr[pick];
          req_q     <= 1'b1;
          addr_q    <= map_addr[pick];
          state     <= REQ;
        end
        REQ: if (bus.sdram_ack) begin
          req_q <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (bus.sdram_rdy) begin
          // Stored under the latched address even if the slot moved on meanwhile.
          data[sel]      <= bus.sdram_din;
          last_addr[sel] <= sel_addr;
          valid[sel]     <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.char_ok    = en[0] && match[0];
  assign bus.scr1_ok    = en[1] && match[1];
  assign bus.scr2_ok    = en[2] && match[2];
  assign bus.obj_ok     = en[3] && match[3];
  assign bus.char_data  = data[0];
  assign bus.scr1_data  = data[1];
  assign bus.scr2_data  = data[2];
  assign bus.obj_data   = data[3][15:0];

  logic unused_bits;

`ifdef JTS16_ROMSTAT_EN
  logic [7:0] fetch_cnt [NSLOT];
  logic [7:0] st_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '0;
      for (int i = 0; i < NSLOT; i++) fetch_cnt[i] <= '0;
    end else begin
      if (state == WAIT && bus.sdram_rdy) fetch_cnt[sel] <= fetch_cnt[sel] + 8'd1;
      st_q <= fetch_cnt[bus.st_addr[1:0]];
    end
  end

  assign bus.st_dout = st_q;
  assign unused_bits = ^{data[3][31:16], bus.st_addr[7:2]};
`else
  assign bus.st_dout = 8'd0;
  assign unused_bits = ^{data[3][31:16], bus.st_addr};
`endif
endmodule
